mux2_merge: RTL and testbench

- Packet-aware 2:1 stream merger: two upstream valid/ready channels ("zero", "one") feed one registered downstream channel.
- Each output beat carries a source tag (out_sel), so a downstream demultiplexer can route it back by sel.
- Round-robin arbitration at packet boundaries. A granted packet holds the output until its last beat is accepted.
- Sits in front of shared PE/buffer write ports where two producers share one path.

---
 rtl/mux2_merge.sv | 150 +++++++++++++++
 tb/tb_mux2_merge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_merge.sv
// mux2_merge: packet-aware 2:1 stream merger with a registered output.
// Round-robin grant at packet boundaries, source tag and per-source packet counters.
module mux2_merge #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zero_valid,
  input  logic [WIDTH-1:0] zero_data,
  input  logic             zero_last,
  output logic             zero_ready,
  input  logic             one_valid,
  input  logic [WIDTH-1:0] one_data,
  input  logic             one_last,
  output logic             one_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   prio_q;
  logic   prio_d;
  logic   gnt0;
  logic   gnt1;
  logic   space;
  logic   xfer0;
  logic   xfer1;

  // Grant: round-robin between packets, locked to the owner inside one.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (zero_valid && one_valid) begin
          gnt0 = !prio_q;
          gnt1 = prio_q;
        end else begin
          gnt0 = zero_valid;
          gnt1 = one_valid;
        end
      end
      BUSY0:   gnt0 = 1'b1;
      BUSY1:   gnt1 = 1'b1;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // Accept only when the output register is free or draining this cycle.
  always_comb begin
    space      = !out_valid || out_ready;
    zero_ready = gnt0 && space && rst_n;
    one_ready  = gnt1 && space && rst_n;
    xfer0      = zero_valid && zero_ready;
    xfer1      = one_valid && one_ready;
  end

  // Packet lock and priority follow the last flag of accepted beats.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (1'b1)
      xfer0: begin
        if (zero_last) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end else begin
          state_d = BUSY0;
        end
      end
      xfer1: begin
        if (one_last) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end else begin
          state_d = BUSY1;
        end
      end
      default: begin
        state_d = state_q;
        prio_d  = prio_q;
      end
    endcase
  end

  // State register; reset drops any packet lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Output beat register: load on transfer, clear when drained, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else if (xfer0) begin
      out_valid <= 1'b1;
      out_data  <= zero_data;
      out_last  <= zero_last;
      out_sel   <= 1'b0;
    end else if (xfer1) begin
      out_valid <= 1'b1;
      out_data  <= one_data;
      out_last  <= one_last;
      out_sel   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Completed-packet counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (xfer0 && zero_last) begin
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      end
      if (xfer1 && one_last) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux2_merge.sv
// tb_mux2_merge: directed stimulus, cycle model scoreboard and literal checks.
// A second instance with 4-bit counters shares all inputs to exercise wrap.
module tb_mux2_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        zero_valid, zero_last, one_valid, one_last, out_ready;
  logic [15:0] zero_data, one_data;

  logic        zero_ready, one_ready, out_valid, out_last, out_sel;
  logic [15:0] out_data, pkt_cnt0, pkt_cnt1;

  logic        zr4, or4, ov4, ol4, os4;
  logic [15:0] od4;
  logic [3:0]  c04, c14;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mux2_merge #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .zero_valid(zero_valid), .zero_data(zero_data),
    .zero_last(zero_last), .zero_ready(zero_ready),
    .one_valid(one_valid), .one_data(one_data),
    .one_last(one_last), .one_ready(one_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  mux2_merge #(.WIDTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .zero_valid(zero_valid), .zero_data(zero_data),
    .zero_last(zero_last), .zero_ready(zr4),
    .one_valid(one_valid), .one_data(one_data),
    .one_last(one_last), .one_ready(or4),
    .out_valid(ov4), .out_data(od4),
    .out_last(ol4), .out_sel(os4),
    .out_ready(out_ready),
    .pkt_cnt0(c04), .pkt_cnt1(c14)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_init = 1'b0;
  logic        m_ov, m_last, m_sel;
  logic [15:0] m_data;
  int          m_owner, m_prio, m_c0, m_c1;

  always begin
    logic        n_ov, n_last, n_sel, room, er0, er1;
    logic [15:0] n_data;
    int          n_owner, n_prio, n_c0, n_c1, want;
    @(negedge clk);
    if (m_owner >= 0) want = m_owner;
    else if (zero_valid && one_valid) want = m_prio;
    else if (zero_valid) want = 0;
    else if (one_valid) want = 1;
    else want = -1;
    room = !m_ov || out_ready;
    er0  = rst_n && room && (want == 0);
    er1  = rst_n && room && (want == 1);
    if (m_init) begin
      chk("m_zero_ready", 32'(zero_ready), 32'(er0));
      chk("m_one_ready", 32'(one_ready), 32'(er1));
      chk("m_out_valid", 32'(out_valid), 32'(m_ov));
      chk("m_out_data", 32'(out_data), 32'(m_data));
      chk("m_out_last", 32'(out_last), 32'(m_last));
      chk("m_out_sel", 32'(out_sel), 32'(m_sel));
      chk("m_cnt0", 32'(pkt_cnt0), 32'(m_c0 % 65536));
      chk("m_cnt1", 32'(pkt_cnt1), 32'(m_c1 % 65536));
      chk("m4_ready", {30'd0, zr4, or4}, {30'd0, er0, er1});
      chk("m4_out", {15'd0, ov4, od4}, {15'd0, m_ov, m_data});
      chk("m4_cnt0", 32'(c04), 32'(m_c0 % 16));
      chk("m4_cnt1", 32'(c14), 32'(m_c1 % 16));
    end
    n_ov = m_ov; n_data = m_data; n_last = m_last; n_sel = m_sel;
    n_owner = m_owner; n_prio = m_prio; n_c0 = m_c0; n_c1 = m_c1;
    if (!rst_n) begin
      n_ov = 0; n_data = 0; n_last = 0; n_sel = 0;
      n_owner = -1; n_prio = 0; n_c0 = 0; n_c1 = 0;
    end else if (zero_valid && er0) begin
      n_ov = 1; n_data = zero_data; n_last = zero_last; n_sel = 0;
      if (zero_last) begin n_owner = -1; n_prio = 1; n_c0 = m_c0 + 1; end
      else n_owner = 0;
    end else if (one_valid && er1) begin
      n_ov = 1; n_data = one_data; n_last = one_last; n_sel = 1;
      if (one_last) begin n_owner = -1; n_prio = 0; n_c1 = m_c1 + 1; end
      else n_owner = 1;
    end else if (out_ready) begin
      n_ov = 0;
    end
    @(posedge clk);
    if (!rst_n) m_init = 1'b1;
    m_ov = n_ov; m_data = n_data; m_last = n_last; m_sel = n_sel;
    m_owner = n_owner; m_prio = n_prio; m_c0 = n_c0; m_c1 = n_c1;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    zero_valid = 0; one_valid = 0;
    zero_last = 0; one_last = 0;
    zero_data = 0; one_data = 0;
  endtask

  initial begin
    int n0, n1;
    logic a0, a1;
    rst_n = 0; out_ready = 1;
    idle_in();
    zero_valid = 1; one_valid = 1;
    step(); step();
    // reset holds readys low even with valids high
    @(negedge clk);
    chk("rst_zero_ready", 32'(zero_ready), 0);
    chk("rst_one_ready", 32'(one_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_cnt", {pkt_cnt0, pkt_cnt1}, 0);
    step();
    rst_n = 1;

    // single-beat packets from both channels alternate
    n0 = 0; n1 = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        zero_valid = 1; one_valid = 1;
        zero_last = 1; one_last = 1;
        zero_data = 16'hA000 + 16'(n0);
        one_data  = 16'hB000 + 16'(n1);
      end else begin
        idle_in();
      end
      @(negedge clk);
      if (c == 0) begin
        chk("first_grant_zero", 32'(zero_ready), 1);
        chk("first_grant_one", 32'(one_ready), 0);
      end
      if (c >= 1) begin
        chk("rr_sel", 32'(out_sel), 32'((c - 1) % 2));
        chk("rr_data", 32'(out_data), ((c - 1) % 2 == 0) ?
            32'(16'hA000 + 16'((c - 1) / 2)) :
            32'(16'hB000 + 16'((c - 1) / 2)));
        chk("rr_valid", 32'(out_valid), 1);
      end
      if (c == 8) begin
        chk("rr_cnt0", 32'(pkt_cnt0), 4);
        chk("rr_cnt1", 32'(pkt_cnt1), 4);
      end
      a0 = zero_valid && zero_ready;
      a1 = one_valid && one_ready;
      step();
      n0 += int'(a0); n1 += int'(a1);
    end

    // 4-beat packet on channel 0 locks out channel 1
    for (int d = 0; d <= 5; d++) begin
      zero_valid = (d < 4);
      zero_data  = 16'hC000 + 16'(d);
      zero_last  = (d == 3);
      one_valid  = (d < 5);
      one_data   = 16'hD000;
      one_last   = 1;
      @(negedge clk);
      if (d < 4) chk("lock_one_ready", 32'(one_ready), 0);
      if (d == 4) chk("after_lock_one_ready", 32'(one_ready), 1);
      if (d >= 1 && d <= 4) begin
        chk("lock_sel", 32'(out_sel), 0);
        chk("lock_data", 32'(out_data), 32'(16'hC000 + 16'(d - 1)));
      end
      if (d == 4) chk("lock_last", 32'(out_last), 1);
      if (d == 5) chk("next_pkt", {out_sel, out_data}, {1'b1, 16'hD000});
      step();
    end
    idle_in();

    // backpressure holds the output and blocks both inputs
    zero_valid = 1; zero_data = 16'h1234; zero_last = 1;
    step();
    zero_data = 16'h5678;
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_data", {out_valid, out_data}, {1'b1, 16'h1234});
      chk("bp_readys", {zero_ready, one_ready}, 0);
      step();
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 32'(zero_ready), 1);
    chk("bp_release_data", 32'(out_data), 32'(16'h1234));
    step();
    idle_in();
    @(negedge clk);
    chk("bp_next_data", {out_valid, out_data}, {1'b1, 16'h5678});
    step();

    // channel 1 owner stalls mid-packet; channel 0 waits
    for (int e = 0; e <= 5; e++) begin
      zero_valid = (e < 5); zero_data = 16'hF000; zero_last = 1;
      one_valid  = (e == 0 || e == 3);
      one_data   = 16'hE000 + 16'(e);
      one_last   = (e == 3);
      @(negedge clk);
      if (e == 0) chk("own1_grant", 32'(one_ready), 1);
      if (e >= 0 && e <= 3) chk("own1_zero_blocked", 32'(zero_ready), 0);
      if (e == 1) chk("own1_beat", {out_sel, out_data}, {1'b1, 16'hE000});
      if (e == 4) chk("own1_release", 32'(zero_ready), 1);
      step();
    end
    idle_in();

    // reset mid-packet, then counter wrap on the 4-bit instance
    one_valid = 1; one_last = 0; one_data = 16'h7777;
    step();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    idle_in();
    zero_valid = 1; zero_last = 1;
    for (int t = 0; t < 17; t++) begin
      zero_data = 16'h0100 + 16'(t);
      step();
    end
    idle_in();
    @(negedge clk);
    chk("wrap_cnt4", 32'(c04), 1);
    chk("wrap_cnt16", 32'(pkt_cnt0), 17);
    chk("wrap_cnt1", 32'(pkt_cnt1), 0);
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
